// File: rtl/alu181_pkg.sv
// Shared types and constants for the sliced 74181-compatible ALU.
package alu181_pkg;

    // Width of one 74181-style slice.
    localparam int SLICE_W = 4;

    // 74181 function select codes; the meaning depends on the mode bit.
    typedef enum logic [3:0] {
        FN_0 = 4'h0,
        FN_1 = 4'h1,
        FN_2 = 4'h2,
        FN_3 = 4'h3,
        FN_4 = 4'h4,
        FN_5 = 4'h5,
        FN_6 = 4'h6,
        FN_7 = 4'h7,
        FN_8 = 4'h8,
        FN_9 = 4'h9,
        FN_A = 4'hA,
        FN_B = 4'hB,
        FN_C = 4'hC,
        FN_D = 4'hD,
        FN_E = 4'hE,
        FN_F = 4'hF
    } alu_fn_t;

    // Mode bit: arithmetic (X + Y + carry) or pure bitwise logic.
    typedef enum logic {
        MODE_ARITH = 1'b0,
        MODE_LOGIC = 1'b1
    } alu_mode_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu181_slice.sv
// One combinational 4-bit 74181 slice. Arithmetic functions are expressed as
// bitwise operand forms X,Y plus carry, so cascading slices is exact.
module alu181_slice
    import alu181_pkg::*;
(
    input  alu_fn_t              s,
    input  alu_mode_t            m,
    input  logic [SLICE_W-1:0]   a4,
    input  logic [SLICE_W-1:0]   b4,
    input  logic                 cin,
    output logic [SLICE_W-1:0]   f4,
    output logic                 cout,
    output logic                 c3
);

    logic [SLICE_W-1:0] x;
    logic [SLICE_W-1:0] y;
    logic [SLICE_W:0]   sum;
    logic [SLICE_W-1:0] lo_sum;
    logic [SLICE_W-1:0] logic_f;

    // Select the two addends for the arithmetic function.
    always_comb begin
        x = '0;
        y = '0;
        case (s)
            FN_0: begin x = a4;        y = '0;        end
            FN_1: begin x = a4 | b4;   y = '0;        end
            FN_2: begin x = a4 | ~b4;  y = '0;        end
            FN_3: begin x = '0;        y = '1;        end
            FN_4: begin x = a4;        y = a4 & ~b4;  end
            FN_5: begin x = a4 | b4;   y = a4 & ~b4;  end
            FN_6: begin x = a4;        y = ~b4;       end
            FN_7: begin x = a4 & ~b4;  y = '1;        end
            FN_8: begin x = a4;        y = a4 & b4;   end
            FN_9: begin x = a4;        y = b4;        end
            FN_A: begin x = a4 | ~b4;  y = a4 & b4;   end
            FN_B: begin x = a4 & b4;   y = '1;        end
            FN_C: begin x = a4;        y = a4;        end
            FN_D: begin x = a4 | b4;   y = a4;        end
            FN_E: begin x = a4 | ~b4;  y = a4;        end
            default: begin x = a4;     y = '1;        end
        endcase
    end

    // Full slice sum, and the low three bits alone to expose the carry into bit 3.
    assign sum    = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, cin};
    assign lo_sum = {1'b0, x[SLICE_W-2:0]} + {1'b0, y[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin};

    // Bitwise logic functions.
    always_comb begin
        logic_f = '0;
        case (s)
            FN_0: logic_f = ~a4;
            FN_1: logic_f = ~(a4 | b4);
            FN_2: logic_f = ~a4 & b4;
            FN_3: logic_f = '0;
            FN_4: logic_f = ~(a4 & b4);
            FN_5: logic_f = ~b4;
            FN_6: logic_f = a4 ^ b4;
            FN_7: logic_f = a4 & ~b4;
            FN_8: logic_f = ~a4 | b4;
            FN_9: logic_f = ~(a4 ^ b4);
            FN_A: logic_f = b4;
            FN_B: logic_f = a4 & b4;
            FN_C: logic_f = '1;
            FN_D: logic_f = a4 | ~b4;
            FN_E: logic_f = a4 | b4;
            default: logic_f = a4;
        endcase
    end

    // Mode mux; logic mode never propagates a carry.
    always_comb begin
        f4   = sum[SLICE_W-1:0];
        cout = sum[SLICE_W];
        c3   = lo_sum[SLICE_W-1];
        if (m == MODE_LOGIC) begin
            f4   = logic_f;
            cout = 1'b0;
            c3   = 1'b0;
        end
    end

endmodule

// File: rtl/alu181_sliced.sv
// Multi-cycle WIDTH-bit 74181 ALU: evaluates SLICES_PER_CYCLE 4-bit slices per
// beat, carrying between beats in carry_q, with valid/ready on both sides.
module alu181_sliced
    import alu181_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int SLICES_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             c_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             ovf,
    output logic             eq,
    output logic             zero
);

    localparam int NUM_SLICES = WIDTH / SLICE_W;
    localparam int BEAT_W     = SLICES_PER_CYCLE * SLICE_W;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int SH_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SLICES - SLICES_PER_CYCLE);
    localparam logic [IDX_W-1:0] IDX_STEP  = IDX_W'(SLICES_PER_CYCLE);
    localparam logic [WIDTH-1:0] BEAT_MASK = WIDTH'({BEAT_W{1'b1}});

    alu_state_t state, state_nxt;

    logic [IDX_W-1:0]  idx;
    logic [SH_W-1:0]   shamt;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    alu_fn_t           s_q;
    alu_mode_t         m_q;

    logic [WIDTH-1:0]  f_q;
    logic              c_out_q;
    logic              ovf_q;
    logic              eq_q;
    logic              zero_q;

    logic [BEAT_W-1:0]           a_beat;
    logic [BEAT_W-1:0]           b_beat;
    logic [BEAT_W-1:0]           f_beat;
    logic [SLICES_PER_CYCLE:0]   chain;
    logic [SLICES_PER_CYCLE-1:0] c3_v;
    logic [WIDTH-1:0]            f_merge;
    logic                        last_beat;

    assign shamt     = SH_W'(int'(idx) * SLICE_W);
    assign a_beat    = a_q[shamt +: BEAT_W];
    assign b_beat    = b_q[shamt +: BEAT_W];
    assign chain[0]  = carry_q;
    assign last_beat = (idx == LAST_IDX);

    // Cascade of slices evaluated this beat, fed by the registered carry.
    for (genvar k = 0; k < SLICES_PER_CYCLE; k++) begin : g_slice
        alu181_slice u_slice (
            .s    (s_q),
            .m    (m_q),
            .a4   (a_beat[k*SLICE_W +: SLICE_W]),
            .b4   (b_beat[k*SLICE_W +: SLICE_W]),
            .cin  (chain[k]),
            .f4   (f_beat[k*SLICE_W +: SLICE_W]),
            .cout (chain[k+1]),
            .c3   (c3_v[k])
        );
    end

    // Result with this beat's bits dropped into place; used for write-back and flags.
    assign f_merge = (f_q & ~(BEAT_MASK << shamt)) | (WIDTH'(f_beat) << shamt);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, step through beats, hold result until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last_beat) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture at accept; not reset since only read while RUN.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
            s_q <= alu_fn_t'(s);
            m_q <= alu_mode_t'(m);
        end
    end

    // Beat counter, inter-beat carry, result bits and final-beat flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            carry_q <= 1'b0;
            f_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            eq_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        idx     <= '0;
                        carry_q <= c_in & ~m;
                    end
                end
                ST_RUN: begin
                    f_q     <= f_merge;
                    carry_q <= chain[SLICES_PER_CYCLE];
                    idx     <= idx + IDX_STEP;
                    if (last_beat) begin
                        c_out_q <= chain[SLICES_PER_CYCLE];
                        ovf_q   <= c3_v[SLICES_PER_CYCLE-1] ^ chain[SLICES_PER_CYCLE];
                        eq_q    <= &f_merge;
                        zero_q  <= (f_merge == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign f         = f_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign eq        = eq_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu181_sliced.sv
// Bench for alu181_sliced: directed spec cases, full s/m sweep and random ops
// against a full-width reference model; a second instance uses two slices per beat.
module tb_alu181_sliced;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [3:0]  s;
    logic        m, c_in;
    logic [15:0] a, b;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [15:0] f, f2;
    logic        c_out, c_out2, ovf, ovf2, eq, eq2, zero, zero2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu181_sliced #(.WIDTH(16), .SLICES_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .m(m), .c_in(c_in), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .f(f),
        .c_out(c_out), .ovf(ovf), .eq(eq), .zero(zero)
    );

    alu181_sliced #(.WIDTH(16), .SLICES_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .s(s), .m(m), .c_in(c_in), .a(a), .b(b),
        .out_valid(out_valid2), .out_ready(out_ready), .f(f2),
        .c_out(c_out2), .ovf(ovf2), .eq(eq2), .zero(zero2)
    );

    task automatic check_v(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full-width reference: F = X + Y + carry as plain 17-bit arithmetic, or bitwise logic.
    task automatic ref_model(input logic [3:0] sel, input logic mode, input logic cin,
                             input logic [15:0] ra, input logic [15:0] rb,
                             output logic [15:0] rf, output logic rco, output logic rov);
        logic [15:0] x, y;
        logic [16:0] sum;
        x = '0; y = '0; rco = 1'b0; rov = 1'b0; rf = '0;
        if (!mode) begin
            case (sel)
                4'h0: begin x = ra;        y = 16'h0000;  end
                4'h1: begin x = ra | rb;   y = 16'h0000;  end
                4'h2: begin x = ra | ~rb;  y = 16'h0000;  end
                4'h3: begin x = 16'h0000;  y = 16'hFFFF;  end
                4'h4: begin x = ra;        y = ra & ~rb;  end
                4'h5: begin x = ra | rb;   y = ra & ~rb;  end
                4'h6: begin x = ra;        y = ~rb;       end
                4'h7: begin x = ra & ~rb;  y = 16'hFFFF;  end
                4'h8: begin x = ra;        y = ra & rb;   end
                4'h9: begin x = ra;        y = rb;        end
                4'hA: begin x = ra | ~rb;  y = ra & rb;   end
                4'hB: begin x = ra & rb;   y = 16'hFFFF;  end
                4'hC: begin x = ra;        y = ra;        end
                4'hD: begin x = ra | rb;   y = ra;        end
                4'hE: begin x = ra | ~rb;  y = ra;        end
                default: begin x = ra;     y = 16'hFFFF;  end
            endcase
            sum = 17'(x) + 17'(y) + 17'(cin);
            rf  = sum[15:0];
            rco = sum[16];
            rov = (x[15] == y[15]) && (rf[15] != x[15]);
        end else begin
            case (sel)
                4'h0: rf = ~ra;
                4'h1: rf = ~(ra | rb);
                4'h2: rf = ~ra & rb;
                4'h3: rf = 16'h0000;
                4'h4: rf = ~(ra & rb);
                4'h5: rf = ~rb;
                4'h6: rf = ra ^ rb;
                4'h7: rf = ra & ~rb;
                4'h8: rf = ~ra | rb;
                4'h9: rf = ~(ra ^ rb);
                4'hA: rf = rb;
                4'hB: rf = ra & rb;
                4'hC: rf = 16'hFFFF;
                4'hD: rf = ra | ~rb;
                4'hE: rf = ra | rb;
                default: rf = ra;
            endcase
        end
    endtask

    // One complete transaction; optionally stalls out_ready for 10 clocks in DONE.
    task automatic run_op(input string tag, input logic [3:0] s_i, input logic m_i, input logic c_i,
                          input logic [15:0] a_i, input logic [15:0] b_i, input bit hold);
        logic [15:0] fe;
        logic        coe, ove;
        int          lat1, lat2;
        ref_model(s_i, m_i, c_i, a_i, b_i, fe, coe, ove);
        check_b({tag, ".in_ready_idle"}, in_ready, 1'b1);
        s = s_i; m = m_i; c_in = c_i; a = a_i; b = b_i; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = 1'($urandom); c_in = 1'($urandom);
        check_b({tag, ".in_ready_busy"}, in_ready, 1'b0);
        lat1 = 0; lat2 = 0;
        for (int i = 1; i <= 10 && lat1 == 0; i++) begin
            @(posedge clk); #1;
            if (lat2 == 0 && out_valid2) lat2 = i;
            if (out_valid) lat1 = i;
        end
        check_i({tag, ".latency_spc1"}, lat1, 4);
        check_i({tag, ".latency_spc2"}, lat2, 2);
        check_v({tag, ".f"},     f,     fe);
        check_b({tag, ".c_out"}, c_out, coe);
        check_b({tag, ".ovf"},   ovf,   ove);
        check_b({tag, ".eq"},    eq,    &fe);
        check_b({tag, ".zero"},  zero,  fe == 16'h0000);
        check_v({tag, ".f2"},    f2,    fe);
        check_b({tag, ".c_out2"}, c_out2, coe);
        check_b({tag, ".ovf2"},  ovf2,  ove);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                in_valid = 1'($urandom);
                a = 16'($urandom); b = 16'($urandom); s = 4'($urandom);
                @(posedge clk); #1;
                check_b({tag, ".hold_valid"}, out_valid, 1'b1);
                check_b({tag, ".hold_in_ready"}, in_ready, 1'b0);
                check_v({tag, ".hold_f"}, f, fe);
                check_b({tag, ".hold_c_out"}, c_out, coe);
                check_b({tag, ".hold_ovf"}, ovf, ove);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_b({tag, ".released_valid"}, out_valid, 1'b0);
        check_b({tag, ".released_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        s = '0; m = 1'b0; c_in = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_b("reset.in_ready", in_ready, 1'b1);
        check_b("reset.out_valid", out_valid, 1'b0);
        check_v("reset.f", f, 16'h0000);
        check_b("reset.zero", zero, 1'b0);
        check_b("reset.eq", eq, 1'b0);
        check_b("reset.c_out", c_out, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add", 4'b1001, 1'b0, 1'b0, 16'h1234, 16'h0FCD, 1'b0);
        check_v("add.const_f", f, 16'h2201);
        check_b("add.const_ovf", ovf, 1'b0);

        run_op("sub_neg", 4'b0110, 1'b0, 1'b1, 16'h0005, 16'h0007, 1'b0);
        check_v("sub_neg.const_f", f, 16'hFFFE);
        check_b("sub_neg.const_c_out", c_out, 1'b0);

        run_op("sub_eq", 4'b0110, 1'b0, 1'b1, 16'h00AA, 16'h00AA, 1'b0);
        check_v("sub_eq.const_f", f, 16'h0000);
        check_b("sub_eq.const_c_out", c_out, 1'b1);
        check_b("sub_eq.const_zero", zero, 1'b1);

        run_op("cmp_eq", 4'b0110, 1'b0, 1'b0, 16'h00AA, 16'h00AA, 1'b0);
        check_v("cmp_eq.const_f", f, 16'hFFFF);
        check_b("cmp_eq.const_eq", eq, 1'b1);

        run_op("xor", 4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 1'b0);
        check_v("xor.const_f", f, 16'h0FF0);
        check_b("xor.const_c_out", c_out, 1'b0);
        check_b("xor.const_ovf", ovf, 1'b0);

        run_op("ovf", 4'b1001, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
        check_v("ovf.const_f", f, 16'h8000);
        check_b("ovf.const_ovf", ovf, 1'b1);
        check_b("ovf.const_c_out", c_out, 1'b0);

        run_op("wrap", 4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        check_v("wrap.const_f", f, 16'hFFFF);
        check_b("wrap.const_c_out", c_out, 1'b1);

        run_op("hold", 4'b1001, 1'b0, 1'b0, 16'h1234, 16'h0FCD, 1'b1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_i("hold.no_ghost_op", seen, 0);

        // Abort during the second RUN beat; f currently holds a nonzero result.
        s = 4'b1001; m = 1'b0; c_in = 1'b0; a = 16'h4321; b = 16'h1111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_b("abort.out_valid", out_valid, 1'b0);
        check_v("abort.f", f, 16'h0000);
        check_b("abort.in_ready", in_ready, 1'b1);
        check_b("abort.c_out", c_out, 1'b0);
        check_b("abort.zero", zero, 1'b0);
        check_v("abort.f2", f2, 16'h0000);
        check_b("abort.in_ready2", in_ready2, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid || out_valid2) seen++;
        end
        check_i("abort.no_output", seen, 0);
        check_b("abort.ready_after", in_ready, 1'b1);

        for (int i = 0; i < 32; i++) begin
            logic [4:0] sm;
            sm = 5'(i);
            run_op($sformatf("sweep_m%0d_s%0h", sm[4], sm[3:0]), sm[3:0], sm[4], 1'($urandom),
                   16'($urandom), 16'($urandom), 1'b0);
        end

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("rand%0d", i), 4'($urandom), 1'($urandom), 1'($urandom),
                   16'($urandom), 16'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
